// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions: key-schedule FSM states, round count,
// round-constant table and the forward S-box lookup.
package aes128_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes128_key_st_e;

  localparam logic [3:0] AES128_NR = 4'd10;

  // Forward key-expansion round constants, indexed by round number 1..10.
  localparam logic [7:0] AES128_RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] AES128_SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Forward AES S-box lookup for one byte.
  function automatic logic [7:0] aes128_sbox(input logic [7:0] b);
    return AES128_SBOX[b];
  endfunction

  // Round-constant word for round n; zero outside 1..10 so a stray counter
  // value can never inject a constant.
  function automatic logic [31:0] aes128_rcon_word(input logic [3:0] n);
    if (n >= 4'd1 && n <= AES128_NR) begin
      return {AES128_RCON[n], 24'h0};
    end
    return 32'h0;
  endfunction

endpackage

// File: rtl/aes128_key_last_gen_if.sv
// Key-load request and round-key-10 result bundle between the key source,
// this generator and the inverse key expansion stage.
interface aes128_key_last_gen_if;
  logic         key_load;
  logic [127:0] cipher_key;
  logic [127:0] round_key_10;
  logic         key_busy;
  logic         key_ready;

  modport master (
    output key_load, cipher_key,
    input  round_key_10, key_busy, key_ready
  );

  modport slave (
    input  key_load, cipher_key,
    output round_key_10, key_busy, key_ready
  );
endinterface

// File: rtl/aes128_key_round.sv
// One forward AES-128 key-expansion round, purely combinational:
// t = SubWord(RotWord(w3)) ^ rcon, then a running XOR chain across the words.
module aes128_key_round
  import aes128_pkg::*;
(
  input  logic [127:0] key,
  input  logic [31:0]  rcon,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3;
  logic [31:0] sub_w3;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key[127:96];
  assign w1 = key[95:64];
  assign w2 = key[63:32];
  assign w3 = key[31:0];

  // Rotate left by one byte: the top byte moves to the bottom.
  assign rot_w3 = {w3[23:0], w3[31:24]};

  // One S-box per byte of the rotated word.
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign sub_w3[8*i +: 8] = aes128_sbox(rot_w3[8*i +: 8]);
  end

  assign t  = sub_w3 ^ rcon;
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_key_last_gen.sv
// Iterative forward AES-128 key schedule: loads a cipher key, runs the ten
// expansion rounds one per clock and publishes round key 10 for the inverse
// key expansion stage. The published key only changes when a run completes.
module aes128_key_last_gen
  import aes128_pkg::*;
(
  input  logic                  clk_sys,
  input  logic                  rst_n,
  aes128_key_last_gen_if.slave  bus
);

  aes128_key_st_e state;
  logic [3:0]     rnd_cnt;
  logic [127:0]   work_key;
  logic [127:0]   result;
  logic           busy_q;
  logic           ready_q;
  logic [127:0]   next_key;

  aes128_key_round u_key_round (
    .key      (work_key),
    .rcon     (aes128_rcon_word(rnd_cnt)),
    .next_key (next_key)
  );

  // FSM, round counter, working key and published result; key_load wins in
  // every state so a reload always restarts from the new key.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: result is a plain register, not a memory, so it is reset here
      // and a reset mid-run can never leave a stale key on the output.
      state    <= IDLE;
      rnd_cnt  <= 4'd0;
      work_key <= 128'h0;
      result   <= 128'h0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else if (bus.key_load) begin
      // NOTE: non-blocking assignments, so every register here sees the
      // pre-edge values of the others regardless of statement order.
      work_key <= bus.cipher_key;
      rnd_cnt  <= 4'd1;
      state    <= RUN;
      busy_q   <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          work_key <= next_key;
          if (rnd_cnt == AES128_NR) begin
            result  <= next_key;
            state   <= DONE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            rnd_cnt <= rnd_cnt + 4'd1;
          end
        end
        default: begin
          // IDLE and DONE hold every register until the next key_load.
        end
      endcase
    end
  end

  assign bus.round_key_10 = result;
  assign bus.key_busy     = busy_q;
  assign bus.key_ready    = ready_q;

endmodule

// File: tb/tb_aes128_key_last_gen.sv
// Self-checking bench for aes128_key_last_gen: FIPS-197 and zero-key vectors,
// restart / reload / held-load / async-reset cases, then randomized loads
// checked against a software key-schedule model whose S-box is derived from
// GF(2^8) inversion plus the affine map.
module tb_aes128_key_last_gen;

  localparam logic [127:0] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] ZERO_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;

  aes128_key_last_gen_if bus ();

  aes128_key_last_gen dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_sbox [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] b);
    logic [7:0] inv = 8'h01;
    if (b == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, b);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  // Full FIPS-197 word expansion; returns words 40..43 (round key 10).
  function automatic logic [127:0] expand_rk10(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {m_sbox[tmp[31:24]], m_sbox[tmp[23:16]], m_sbox[tmp[15:8]], m_sbox[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[40], w[41], w[42], w[43]};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic ld, input logic [127:0] k);
    bus.key_load   = ld;
    bus.cipher_key = k;
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Load a key and verify exactly ten cycles of busy, no early ready, the
  // output holding its previous value, then the expected round key 10.
  task automatic run_and_check(input string tag, input logic [127:0] key,
                               input logic [127:0] exp, input logic [127:0] hold,
                               input bit probe_rk1);
    int busy_n = 0;
    int early  = 0;
    int moved  = 0;
    step(1'b1, key);
    check({tag, "_ready_after_load"}, 128'(bus.key_ready), 128'(0));
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step(1'b0, rand128());
      if (probe_rk1 && i == 1) check({tag, "_work_key_rnd1"}, dut.work_key, FIPS_RK1);
      if (bus.key_busy) busy_n++;
      if (bus.key_ready) early++;
      if (bus.round_key_10 !== hold) moved++;
    end
    step(1'b0, 128'h0);
    check({tag, "_busy_cycles"}, 128'(busy_n), 128'(10));
    check({tag, "_early_ready"}, 128'(early), 128'(0));
    check({tag, "_output_held"}, 128'(moved), 128'(0));
    check({tag, "_ready"}, 128'(bus.key_ready), 128'(1));
    check({tag, "_busy_done"}, 128'(bus.key_busy), 128'(0));
    check({tag, "_rk10"}, bus.round_key_10, exp);
  endtask

  // Scoreboard state for the randomized phase.
  bit           m_active = 1'b0;
  int           m_since  = 0;
  logic [127:0] m_key    = '0;
  logic [127:0] m_result = '0;
  bit           m_ready  = 1'b0;
  int           n_loads  = 0;

  task automatic rstep(input logic ld, input logic [127:0] k);
    step(ld, k);
    if (ld) begin
      m_active = 1'b1;
      m_since  = 0;
      m_key    = k;
      m_ready  = 1'b0;
      n_loads++;
    end else if (m_active) begin
      m_since++;
      if (m_since == 10) begin
        m_result = expand_rk10(m_key);
        m_ready  = 1'b1;
        m_active = 1'b0;
      end
    end
    check("rnd_ready", 128'(bus.key_ready), 128'(m_ready));
    check("rnd_busy", 128'(bus.key_busy), 128'(m_active));
    check("rnd_rk10", bus.round_key_10, m_result);
  endtask

  initial begin
    int quiet_ready;
    int quiet_busy;
    bus.key_load   = 1'b0;
    bus.cipher_key = 128'h0;
    for (int i = 0; i < 256; i++) m_sbox[i] = sbox_calc(8'(i));

    // Reset state.
    #12 rst_n = 1'b1;
    check("reset_rk10", bus.round_key_10, 128'h0);
    check("reset_busy", 128'(bus.key_busy), 128'(0));
    check("reset_ready", 128'(bus.key_ready), 128'(0));
    step(1'b0, 128'h0);
    step(1'b0, 128'h0);
    check("idle_ready", 128'(bus.key_ready), 128'(0));

    // FIPS-197 vector, then reload from DONE with the zero key.
    run_and_check("fips", FIPS_KEY, FIPS_RK10, 128'h0, 1'b1);
    run_and_check("zero", 128'h0, ZERO_RK10, FIPS_RK10, 1'b0);

    // Restart: zero key at cycle 0, FIPS key at cycle 4.
    quiet_ready = 0;
    step(1'b1, 128'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 128'h0);
      if (bus.key_ready) quiet_ready++;
    end
    check("restart_no_ready", 128'(quiet_ready), 128'(0));
    run_and_check("restart", FIPS_KEY, FIPS_RK10, ZERO_RK10, 1'b0);

    // Held-high load: only the last sampled key counts.
    for (int i = 0; i < 3; i++) step(1'b1, rand128());
    run_and_check("held", 128'h0, ZERO_RK10, FIPS_RK10, 1'b0);

    // Async reset mid-run, asserted between clock edges.
    step(1'b1, FIPS_KEY);
    for (int i = 0; i < 4; i++) step(1'b0, 128'h0);
    #2 rst_n = 1'b0;
    #1;
    check("areset_rk10", bus.round_key_10, 128'h0);
    check("areset_busy", 128'(bus.key_busy), 128'(0));
    check("areset_ready", 128'(bus.key_ready), 128'(0));
    @(negedge clk_sys);
    rst_n = 1'b1;
    quiet_ready = 0;
    quiet_busy  = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, rand128());
      if (bus.key_ready) quiet_ready++;
      if (bus.key_busy) quiet_busy++;
    end
    check("post_reset_ready", 128'(quiet_ready), 128'(0));
    check("post_reset_busy", 128'(quiet_busy), 128'(0));
    check("post_reset_rk10", bus.round_key_10, 128'h0);

    // Randomized loads: single, held-high, back-to-back and spaced.
    while (n_loads < 1100) begin
      int mode;
      int nld;
      int gap;
      mode = int'($urandom_range(0, 9));
      nld  = (mode < 2) ? int'($urandom_range(2, 4)) : 1;
      gap  = int'($urandom_range(0, 13));
      for (int i = 0; i < nld; i++) rstep(1'b1, rand128());
      for (int i = 0; i < gap; i++) rstep(1'b0, rand128());
    end
    for (int i = 0; i < 12; i++) rstep(1'b0, 128'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
